line_rasterizer: RTL and testbench
==================================

LINE_RASTERIZER -- requirements
Module: line_rasterizer

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port draw_en  input  1  line request, held high by upstream controller until draw_done is seen.
REQ-004 SHALL have ports x0, y0  input  8 each  start point, unsigned.
REQ-005 SHALL have ports x1, y1  input  8 each  end point, unsigned.
REQ-006 SHALL have ports pixel_x, pixel_y  output  8 each  current pixel coordinate, registered.
REQ-007 SHALL have port pixel_valid  output  1  pixel_x/pixel_y hold a pixel to write.
REQ-008 SHALL have port pixel_ready  input  1  downstream accepts pixel this cycle.
REQ-009 SHALL have port draw_done  output  1  one-cycle pulse; line complete.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement states IDLE, LOAD, STEP, DONE, REARM.
REQ-012 IDLE: on draw_en=1, SHALL latch x0,y0,x1,y1 and go to LOAD; otherwise stay.
REQ-013 LOAD: SHALL register dx=|x1-x0|, dy=|y1-y0| (8-bit unsigned), sx/sy = +1 if end >= start else -1, err = dx-dy (10-bit signed), cur=(x0,y0); then go to STEP.
REQ-014 First pixel_valid SHALL appear exactly 2 cycles after the IDLE cycle in which draw_en was sampled high.
REQ-015 STEP: pixel_valid=1 with pixel=cur; while pixel_ready=0, pixel_x/pixel_y/err SHALL hold unchanged.
REQ-016 On accept (valid & ready) with cur != end: e2=2*err (11-bit signed); if e2 >= -dy then err-=dy, x+=sx; if e2 <= dx then err+=dx, y+=sy; both updates SHALL apply in the same cycle using the pre-update e2.
REQ-017 On accept with cur == (x1,y1): SHALL go to DONE; endpoint inclusive; total pixels = max(dx,dy)+1.
REQ-018 Coordinate arithmetic SHALL never wrap; x,y stay within [min,max] of the endpoints.
REQ-019 x0==x1 and y0==y1 SHALL emit exactly one pixel.
REQ-020 DONE: draw_done=1, pixel_valid=0 for exactly one cycle, then REARM.
REQ-021 REARM: SHALL wait until draw_en=0, then IDLE; a held-high draw_en SHALL NOT start a second line.
REQ-022 draw_en falling during LOAD/STEP SHALL be ignored; the line completes.
REQ-023 Input coordinate changes after the IDLE->LOAD transition SHALL NOT affect the line in progress.
REQ-024 pixel_valid SHALL be 0 in IDLE, LOAD, DONE, REARM; pixel_x/pixel_y SHALL be 0 whenever pixel_valid=0.

Reset
REQ-025 n_rst=0 SHALL force IDLE and pixel_x=0, pixel_y=0, pixel_valid=0, draw_done=0, busy=0, err=0 immediately, including mid-line.
REQ-026 After reset release SHALL accept a new draw_en on the first clk edge.

Structure
REQ-027 State enum and COORD_W=8 SHALL live in the shared gpu package used by bresenham blocks.
REQ-028 Next-point arithmetic (e2, err, x, y update) SHALL be one combinational sub-module, bresenham_step.
REQ-029 State register and datapath registers SHALL be flip-flops only; no latches.

Verification
REQ-030 (0,0)->(3,0), ready=1: pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles, draw_done next cycle.
REQ-031 (2,5)->(0,0), ready=1: pixels (2,5),(2,4),(1,3),(1,2),(0,1),(0,0), then draw_done.
REQ-032 (0,0)->(3,3) with pixel_ready low for 3 cycles on 2nd pixel: (1,1) held stable 4 cycles, sequence (0,0),(1,1),(2,2),(3,3) intact.
REQ-033 (7,7)->(7,7): one pixel (7,7), draw_done; draw_en held high 5 more cycles -> no second pixel, busy stays 1 until draw_en=0.
REQ-034 Reset asserted on 3rd pixel of (0,0)->(10,4): all outputs 0 immediately; new line (1,1)->(2,1) after release emits (1,1),(2,1).

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the bresenham line blocks: coordinate/error widths,
// rasterizer state encoding and a small absolute-difference helper.
package gpu_pkg;

    localparam int COORD_W = 8;
    // Error term needs two extra bits: one for sign, one for dx+dy headroom.
    localparam int ERR_W   = COORD_W + 2;

    typedef logic [COORD_W-1:0]       coord_t;
    typedef logic signed [ERR_W-1:0]  err_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_STEP  = 3'd2,
        ST_DONE  = 3'd3,
        ST_REARM = 3'd4
    } ras_state_t;

    function automatic coord_t abs_diff(input coord_t a, input coord_t b);
        return (a >= b) ? coord_t'(a - b) : coord_t'(b - a);
    endfunction

endpackage

// File: rtl/bresenham_step.sv
// Combinational next-point computation for one bresenham step: derives e2
// from the current error and applies the x and y updates in the same cycle.
module bresenham_step
    import gpu_pkg::*;
(
    input  err_t        err_i,
    input  coord_t      dx_i,
    input  coord_t      dy_i,
    input  logic        sx_neg_i,
    input  logic        sy_neg_i,
    input  coord_t      cur_x_i,
    input  coord_t      cur_y_i,
    input  coord_t      end_x_i,
    input  coord_t      end_y_i,
    output err_t        err_o,
    output coord_t      x_o,
    output coord_t      y_o
);

    localparam int E2_W  = ERR_W + 1;
    localparam int PAD_W = E2_W - COORD_W;

    logic signed [E2_W-1:0] e2;
    logic signed [E2_W-1:0] dx_s;
    logic signed [E2_W-1:0] dy_s;
    logic signed [E2_W-1:0] err_acc;
    logic                   step_x;
    logic                   step_y;

    always_comb begin
        e2      = $signed({err_i, 1'b0});
        dx_s    = $signed({{PAD_W{1'b0}}, dx_i});
        dy_s    = $signed({{PAD_W{1'b0}}, dy_i});
        // The endpoint guards keep a coordinate from ever moving past its
        // end value, so the walk cannot wrap at the edges of the range.
        step_x  = (e2 >= -dy_s) && (cur_x_i != end_x_i);
        step_y  = (e2 <= dx_s)  && (cur_y_i != end_y_i);

        err_acc = $signed({err_i[ERR_W-1], err_i});
        if (step_x) begin
            err_acc = err_acc - dy_s;
        end
        if (step_y) begin
            err_acc = err_acc + dx_s;
        end
        err_o = err_acc[ERR_W-1:0];

        x_o = cur_x_i;
        if (step_x) begin
            x_o = sx_neg_i ? coord_t'(cur_x_i - 1'b1) : coord_t'(cur_x_i + 1'b1);
        end
        y_o = cur_y_i;
        if (step_y) begin
            y_o = sy_neg_i ? coord_t'(cur_y_i - 1'b1) : coord_t'(cur_y_i + 1'b1);
        end
    end

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: latches a line request, then emits one pixel per
// accepted valid/ready handshake from start to end point inclusive.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for draw_en; endpoints latched on the start edge
//   LOAD     | derive dx, dy, step directions and initial error
//   STEP     | present current pixel; advance on accept
//   DONE     | one-cycle draw_done pulse
//   REARM    | wait for draw_en to drop before allowing another line
module line_rasterizer
    import gpu_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               draw_en,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               pixel_valid,
    input  logic               pixel_ready,
    output logic               draw_done,
    output logic               busy
);

    ras_state_t state_q, state_d;

    coord_t start_x_q, start_x_d;
    coord_t start_y_q, start_y_d;
    coord_t end_x_q,   end_x_d;
    coord_t end_y_q,   end_y_d;
    coord_t dx_q,      dx_d;
    coord_t dy_q,      dy_d;
    logic   sx_neg_q,  sx_neg_d;
    logic   sy_neg_q,  sy_neg_d;
    err_t   err_q,     err_d;
    coord_t cur_x_q,   cur_x_d;
    coord_t cur_y_q,   cur_y_d;

    err_t   step_err;
    coord_t step_x;
    coord_t step_y;

    logic   latch_en;
    logic   load_en;
    logic   accept;
    logic   at_end;

    assign at_end = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);

    bresenham_step u_step (
        .err_i    (err_q),
        .dx_i     (dx_q),
        .dy_i     (dy_q),
        .sx_neg_i (sx_neg_q),
        .sy_neg_i (sy_neg_q),
        .cur_x_i  (cur_x_q),
        .cur_y_i  (cur_y_q),
        .end_x_i  (end_x_q),
        .end_y_i  (end_y_q),
        .err_o    (step_err),
        .x_o      (step_x),
        .y_o      (step_y)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (draw_en) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_STEP;
            ST_STEP:  if (pixel_ready && at_end) state_d = ST_DONE;
            ST_DONE:  state_d = ST_REARM;
            ST_REARM: if (!draw_en) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pixel_valid = (state_q == ST_STEP);
        draw_done   = (state_q == ST_DONE);
        busy        = (state_q != ST_IDLE);
        latch_en    = (state_q == ST_IDLE) && draw_en;
        load_en     = (state_q == ST_LOAD);
        accept      = pixel_valid && pixel_ready;
        // Coordinates are forced to zero whenever no pixel is offered.
        pixel_x     = pixel_valid ? cur_x_q : '0;
        pixel_y     = pixel_valid ? cur_y_q : '0;
    end

    always_comb begin
        start_x_d = start_x_q;
        start_y_d = start_y_q;
        end_x_d   = end_x_q;
        end_y_d   = end_y_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        sx_neg_d  = sx_neg_q;
        sy_neg_d  = sy_neg_q;
        err_d     = err_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;

        if (latch_en) begin
            start_x_d = x0;
            start_y_d = y0;
            end_x_d   = x1;
            end_y_d   = y1;
        end

        if (load_en) begin
            dx_d     = abs_diff(end_x_q, start_x_q);
            dy_d     = abs_diff(end_y_q, start_y_q);
            sx_neg_d = (end_x_q < start_x_q);
            sy_neg_d = (end_y_q < start_y_q);
            err_d    = err_t'($signed({2'b00, abs_diff(end_x_q, start_x_q)})
                            - $signed({2'b00, abs_diff(end_y_q, start_y_q)}));
            cur_x_d  = start_x_q;
            cur_y_d  = start_y_q;
        end

        if (accept && !at_end) begin
            err_d   = step_err;
            cur_x_d = step_x;
            cur_y_d = step_y;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            start_x_q <= '0;
            start_y_q <= '0;
            end_x_q   <= '0;
            end_y_q   <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            sx_neg_q  <= 1'b0;
            sy_neg_q  <= 1'b0;
            err_q     <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
        end else begin
            start_x_q <= start_x_d;
            start_y_q <= start_y_d;
            end_x_q   <= end_x_d;
            end_y_q   <= end_y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            sx_neg_q  <= sx_neg_d;
            sy_neg_q  <= sy_neg_d;
            err_q     <= err_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: table of lines with hand-derived pixel
// sequences, plus stall, held-request and mid-line reset sequences.
module tb_line_rasterizer;

    logic       clk;
    logic       n_rst;
    logic       draw_en;
    logic [7:0] x0, y0, x1, y1;
    logic [7:0] pixel_x, pixel_y;
    logic       pixel_valid;
    logic       pixel_ready;
    logic       draw_done;
    logic       busy;

    int total = 0;
    int bad   = 0;

    line_rasterizer dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .draw_en     (draw_en),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .draw_done   (draw_done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pix holds {x,y} pairs, pixel 0 in the least significant 16 bits.
    typedef struct packed {
        logic [7:0]   x0, y0, x1, y1;
        logic [31:0]  n;
        logic [191:0] pix;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one line. stall_idx/stall_n hold ready low on one pixel;
    // drop_early releases draw_en during LOAD; hold keeps draw_en high in REARM.
    task automatic run_line(input vec_t v, input int stall_idx, input int stall_n,
                            input bit drop_early, input int hold);
        logic [15:0] exp;
        x0 = v.x0; y0 = v.y0; x1 = v.x1; y1 = v.y1;
        draw_en = 1'b1;
        pixel_ready = 1'b1;
        step();
        // LOAD: scramble the inputs, they must no longer matter
        x0 = 8'hA5; y0 = 8'h5A; x1 = 8'hFF; y1 = 8'h00;
        if (drop_early) draw_en = 1'b0;
        chk("load_valid", {31'd0, pixel_valid}, 32'd0);
        chk("load_busy", {31'd0, busy}, 32'd1);
        step();
        for (int i = 0; i < int'(v.n); i++) begin
            exp = v.pix[i*16 +: 16];
            if (i == stall_idx) begin
                for (int s = 0; s < stall_n; s++) begin
                    pixel_ready = 1'b0;
                    chk("stall_pixel", {15'd0, pixel_valid, pixel_x, pixel_y}, {15'd0, 1'b1, exp});
                    step();
                end
            end
            pixel_ready = 1'b1;
            chk("pixel", {15'd0, pixel_valid, pixel_x, pixel_y}, {15'd0, 1'b1, exp});
            chk("pixel_nodone", {31'd0, draw_done}, 32'd0);
            step();
        end
        chk("done_pulse", {31'd0, draw_done}, 32'd1);
        chk("done_outputs", {15'd0, pixel_valid, pixel_x, pixel_y}, 32'd0);
        chk("done_busy", {31'd0, busy}, 32'd1);
        step();
        chk("rearm_done_low", {31'd0, draw_done}, 32'd0);
        chk("rearm_busy", {31'd0, busy}, 32'd1);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_no_pixel", {31'd0, pixel_valid}, 32'd0);
            chk("hold_busy", {31'd0, busy}, 32'd1);
        end
        draw_en = 1'b0;
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_valid", {31'd0, pixel_valid}, 32'd0);
    endtask

    initial begin
        tbl[0] = '{x0:8'd0, y0:8'd0, x1:8'd3, y1:8'd0, n:32'd4,
                   pix:192'({16'h0300, 16'h0200, 16'h0100, 16'h0000})};
        tbl[1] = '{x0:8'd2, y0:8'd5, x1:8'd0, y1:8'd0, n:32'd6,
                   pix:192'({16'h0000, 16'h0001, 16'h0102, 16'h0103, 16'h0204, 16'h0205})};
        tbl[2] = '{x0:8'd5, y0:8'd2, x1:8'd1, y1:8'd4, n:32'd5,
                   pix:192'({16'h0104, 16'h0204, 16'h0303, 16'h0403, 16'h0502})};
        tbl[3] = '{x0:8'd3, y0:8'd6, x1:8'd3, y1:8'd2, n:32'd5,
                   pix:192'({16'h0302, 16'h0303, 16'h0304, 16'h0305, 16'h0306})};
        tbl[4] = '{x0:8'd0, y0:8'd0, x1:8'd3, y1:8'd3, n:32'd4,
                   pix:192'({16'h0303, 16'h0202, 16'h0101, 16'h0000})};

        n_rst = 1'b0;
        draw_en = 1'b0;
        pixel_ready = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        #12;
        chk("reset_outputs", {13'd0, busy, draw_done, pixel_valid, pixel_x, pixel_y}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int k = 0; k < 4; k++) begin
            run_line(tbl[k], -1, 0, (k == 2), 0);
        end

        // ready held low for 3 cycles on the second pixel
        run_line(tbl[4], 1, 3, 1'b0, 0);

        // single point, request held high after completion
        run_line('{x0:8'd7, y0:8'd7, x1:8'd7, y1:8'd7, n:32'd1, pix:192'(16'h0707)}, -1, 0, 1'b0, 5);

        // mid-line reset on the third pixel of (0,0)->(10,4)
        x0 = 8'd0; y0 = 8'd0; x1 = 8'd10; y1 = 8'd4;
        draw_en = 1'b1;
        pixel_ready = 1'b1;
        step();
        step();
        chk("long_p0", {15'd0, pixel_valid, pixel_x, pixel_y}, {15'd0, 1'b1, 16'h0000});
        step();
        chk("long_p1", {15'd0, pixel_valid, pixel_x, pixel_y}, {15'd0, 1'b1, 16'h0100});
        step();
        chk("long_p2", {15'd0, pixel_valid, pixel_x, pixel_y}, {15'd0, 1'b1, 16'h0201});
        #1;
        n_rst = 1'b0;
        #1;
        chk("midline_reset", {13'd0, busy, draw_done, pixel_valid, pixel_x, pixel_y}, 32'd0);
        draw_en = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        run_line('{x0:8'd1, y0:8'd1, x1:8'd2, y1:8'd1, n:32'd2,
                   pix:192'({16'h0201, 16'h0101})}, -1, 0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
